// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring shift-subtract step per cycle.
// Fixed XLEN+1 cycles from acceptance to a one-cycle done pulse; start is ignored while busy.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [5:0] LAST = 6'(XLEN);

   state_t          state_q, state_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            neg_q, neg_d;
   logic            dbz_q, dbz_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            a_sgn, b_sgn;
   logic [XLEN-1:0] a_mag, b_mag;

   always_comb begin
      a_sgn = op_a[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                              (funct3 == 3'b100) | (funct3 == 3'b110));
      b_sgn = op_b[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                              (funct3 == 3'b110));
      a_mag = a_sgn ? -op_a : op_a;
      b_mag = b_sgn ? -op_b : op_b;
   end

   // hi holds the partial product / partial remainder; lo the multiplier / quotient bits
   logic [XLEN:0] mul_sum;
   logic [XLEN:0] div_shift;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
      div_shift = {hi_q, lo_q[XLEN-1]};
   end

   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, final_res;

   always_comb begin
      prod_s    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      quo_s     = neg_q ? -lo_q : lo_q;
      rem_s     = neg_q ? -hi_q : hi_q;
      final_res = '0;
      case (op_q)
         3'b000:                 final_res = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
         // signed overflow falls out of the magnitude path; only x/0 quotient needs forcing
         3'b100, 3'b101:         final_res = dbz_q ? '1 : quo_s;
         default:                final_res = rem_s;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dvs_d    = dvs_q;
      neg_d    = neg_q;
      dbz_d    = dbz_q;
      result_d = result_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CALC;
               cnt_d   = '0;
               op_d    = funct3;
               hi_d    = '0;
               lo_d    = funct3[2] ? a_mag : b_mag;
               dvs_d   = funct3[2] ? b_mag : a_mag;
               neg_d   = (funct3[2] & funct3[1]) ? a_sgn : (a_sgn ^ b_sgn);
               dbz_d   = (op_b == '0);
            end
         end
         CALC: begin
            if (cnt_q == LAST) begin
               state_d  = DONE;
               cnt_d    = '0;
               result_d = final_res;
               done_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 6'd1;
               if (op_q[2]) begin
                  if (div_shift >= {1'b0, dvs_q}) begin
                     hi_d = div_shift[XLEN-1:0] - dvs_q;
                     lo_d = {lo_q[XLEN-2:0], 1'b1};
                  end else begin
                     hi_d = div_shift[XLEN-1:0];
                     lo_d = {lo_q[XLEN-2:0], 1'b0};
                  end
               end else begin
                  hi_d = mul_sum[XLEN:1];
                  lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (kill) begin
         state_d  = IDLE;
         cnt_d    = '0;
         result_d = result_q;
         done_d   = 1'b0;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         dvs_q    <= '0;
         neg_q    <= 1'b0;
         dbz_q    <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         dvs_q    <= dvs_d;
         neg_q    <= neg_d;
         dbz_q    <= dbz_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M vectors, randomized ops against an arithmetic model,
// handshake, kill and reset scenarios.
module tb_muldiv_unit;
   localparam int XLEN = 32;
   localparam int LAT  = 33;

   logic        clk = 1'b0;
   logic        rst, start, kill;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic        busy, done;
   logic [31:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .kill   (kill),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] pv;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      ia = a;
      ib = b;
      pv = '0;
      case (f3)
         3'd0: begin pv = ua * ub; return pv[31:0]; end
         3'd1: begin pv = sa * sb; return pv[63:32]; end
         3'd2: begin pv = sa * ub; return pv[63:32]; end
         3'd3: begin pv = ua * ub; return pv[63:32]; end
         3'd4: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
         end
         3'd5: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: begin
            if (b == 32'h0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Issue one op; optionally inject a disturbance (1 start, 2 kill, 3 rst) for one cycle at sample dist_n.
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int dist_n, input int dist_kind,
                        output logic [31:0] res, output int lat, output bit busy_ok,
                        output bit post_ok, output logic busy_aft, output logic [31:0] res_aft);
      @(negedge clk);
      start = 1'b1; kill = 1'b0; funct3 = f3; op_a = a; op_b = b;
      @(negedge clk);
      start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
      lat = -1; busy_ok = 1'b1; post_ok = 1'b0;
      res = 'x; busy_aft = 1'bx; res_aft = 'x;
      for (int n = 0; n <= 40; n++) begin
         if (n > 0) @(negedge clk);
         if (n == dist_n + 1) begin
            busy_aft = busy; res_aft = result;
            start = 1'b0; kill = 1'b0; rst = 1'b0;
         end
         if (n <= LAT && busy !== 1'b1) busy_ok = 1'b0;
         if (n == dist_n) begin
            case (dist_kind)
               1: begin start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; end
               2: kill = 1'b1;
               3: rst = 1'b1;
               default: ;
            endcase
         end
         if (done === 1'b1) begin
            lat = n; res = result;
            break;
         end
      end
      if (lat >= 0) begin
         @(negedge clk);
         post_ok = (done === 1'b0) && (busy === 1'b0) && (result === res);
      end
      start = 1'b0; kill = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; kill = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4;
      repeat (3) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_tests++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_tests++;
      if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
      rst = 1'b0; start = 1'b0; kill = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept: busy %b expected 0", busy); end
   endtask

   logic [2:0]  dv_f [13] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd4};
   logic [31:0] dv_a [13] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000,
                              32'h8000_0000, 32'hFFFF_FFF9};
   logic [31:0] dv_b [13] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
   logic [31:0] dv_e [13] = '{32'd42, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000,
                              32'h0, 32'hFFFF_FFFF};

   task automatic test_directed();
      logic [31:0] res, res_aft;
      logic        busy_aft;
      int          lat;
      bit          busy_ok, post_ok;
      for (int i = 0; i < 13; i++) begin
         do_op(dv_f[i], dv_a[i], dv_b[i], -10, 0, res, lat, busy_ok, post_ok, busy_aft, res_aft);
         n_tests++;
         if (res !== dv_e[i]) begin
            n_fail++; $display("FAIL directed_%0d_result: got %h expected %h", i, res, dv_e[i]);
         end
         n_tests++;
         if (lat != LAT) begin
            n_fail++; $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, LAT);
         end
         n_tests++;
         if (!busy_ok) begin n_fail++; $display("FAIL directed_%0d_busy: busy dropped, expected high", i); end
         n_tests++;
         if (!post_ok) begin
            n_fail++; $display("FAIL directed_%0d_after_done: busy %b done %b expected 0/0, result held", i, busy, done);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, res, res_aft, exp;
      logic [2:0]  f;
      logic        busy_aft;
      int          lat;
      bit          busy_ok, post_ok;
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7)); a = pick(); b = pick();
         exp = ref_model(f, a, b);
         do_op(f, a, b, -10, 0, res, lat, busy_ok, post_ok, busy_aft, res_aft);
         n_tests++;
         if (res !== exp || lat != LAT) begin
            n_fail++;
            $display("FAIL random_%0d f3=%0d a=%h b=%h: got %h lat %0d expected %h lat %0d", i, f, a, b, res, lat, exp, LAT);
         end
      end
   endtask

   task automatic test_start_while_busy();
      logic [31:0] res, res_aft;
      logic        busy_aft;
      int          lat;
      bit          busy_ok, post_ok;
      do_op(3'd0, 32'd7, 32'd6, 5, 1, res, lat, busy_ok, post_ok, busy_aft, res_aft);
      n_tests++;
      if (res !== 32'd42 || lat != LAT) begin
         n_fail++; $display("FAIL start_while_busy: got %h lat %0d expected 0000002a lat %0d", res, lat, LAT);
      end
      n_tests++;
      if (!post_ok) begin n_fail++; $display("FAIL start_while_busy_queued: busy %b after done expected 0", busy); end
   endtask

   task automatic test_kill();
      logic [31:0] res, res_aft;
      logic        busy_aft;
      int          lat;
      bit          busy_ok, post_ok;
      do_op(3'd5, 32'd100, 32'd7, -10, 0, res, lat, busy_ok, post_ok, busy_aft, res_aft);
      do_op(3'd0, 32'd7, 32'd6, 10, 2, res, lat, busy_ok, post_ok, busy_aft, res_aft);
      n_tests++;
      if (busy_aft !== 1'b0) begin n_fail++; $display("FAIL kill_busy: got %b expected 0", busy_aft); end
      n_tests++;
      if (lat != -1) begin n_fail++; $display("FAIL kill_no_done: done seen at %0d expected none", lat); end
      n_tests++;
      if (result !== 32'd14) begin n_fail++; $display("FAIL kill_result_held: got %h expected 0000000e", result); end
      do_op(3'd0, 32'd3, 32'd5, LAT, 2, res, lat, busy_ok, post_ok, busy_aft, res_aft);
      n_tests++;
      if (res !== 32'd15 || lat != LAT || !post_ok) begin
         n_fail++; $display("FAIL kill_in_done: got %h lat %0d expected 0000000f lat %0d then idle", res, lat, LAT);
      end
   endtask

   task automatic test_start_kill_idle();
      bit seen = 1'b0;
      @(negedge clk);
      start = 1'b1; kill = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      n_tests++;
      if (seen) begin n_fail++; $display("FAIL start_kill_idle: accepted, expected busy/done to stay 0"); end
      n_tests++;
      if (result !== 32'd15) begin n_fail++; $display("FAIL start_kill_idle_result: got %h expected 0000000f", result); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res, res_aft;
      logic        busy_aft;
      int          lat;
      bit          busy_ok, post_ok;
      do_op(3'd0, 32'd11, 32'd13, 15, 3, res, lat, busy_ok, post_ok, busy_aft, res_aft);
      n_tests++;
      if (busy_aft !== 1'b0 || res_aft !== 32'h0) begin
         n_fail++; $display("FAIL reset_mid: busy %b result %h expected 0 and 00000000", busy_aft, res_aft);
      end
      n_tests++;
      if (lat != -1) begin n_fail++; $display("FAIL reset_mid_no_done: done at %0d expected none", lat); end
      do_op(3'd0, 32'd7, 32'd6, -10, 0, res, lat, busy_ok, post_ok, busy_aft, res_aft);
      n_tests++;
      if (res !== 32'd42 || lat != LAT) begin
         n_fail++; $display("FAIL reset_then_op: got %h lat %0d expected 0000002a lat %0d", res, lat, LAT);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
      test_reset();
      test_directed();
      test_random();
      test_start_while_busy();
      test_kill();
      test_start_kill_idle();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width and the iteration count; only 32 is required to be supported.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port rst, input, 1: synchronous active-high reset.
REQ-005 Port start, input, 1: request a new operation; sampled only in IDLE.
REQ-006 Port kill, input, 1: pipeline flush; aborts any operation.
REQ-007 Port funct3, input, 3: RV32M op code; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 Port op_a, input, XLEN: rs1 operand (register-file read port 1 data).
REQ-009 Port op_b, input, XLEN: rs2 operand (register-file read port 2 data).
REQ-010 Port busy, output, 1: high while an operation is in flight (CALC or DONE).
REQ-011 Port done, output, 1: one-cycle pulse; result is valid in that cycle.
REQ-012 Port result, output, XLEN: registered result, for the writeback path to the register file.

Function
REQ-013 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-014 Transition IDLE->CALC: on an edge with start=1 and kill=0 (acceptance); funct3, op_a and op_b are captured at that edge, and later input changes are ignored.
REQ-015 In CALC, one shift-add (multiply) or restoring shift-subtract (divide) iteration SHALL run per cycle, counted by a 6-bit iteration counter.
REQ-016 Transition CALC->DONE: after exactly XLEN iterations.
REQ-017 Transition DONE->IDLE: unconditionally on the next edge.
REQ-018 Latency SHALL be fixed for all ops, including special cases: with acceptance at edge T, done=1 during the cycle after edge T+XLEN+1 only (33 cycles after acceptance for XLEN=32).
REQ-019 busy SHALL be 1 in CALC and DONE and 0 in IDLE; start while busy SHALL be ignored (no queuing).
REQ-020 Signed ops SHALL convert operands to magnitudes and then apply the result sign: MULH treats a and b as signed; MULHSU treats a as signed and b as unsigned; DIV/REM signed; MULHU/DIVU/REMU unsigned.
REQ-021 MUL SHALL return the low XLEN bits of the 2*XLEN product; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
REQ-022 Remainder sign SHALL follow the dividend; quotient SHALL be truncated toward zero.
REQ-023 Divide by zero (op_b=0): DIV/DIVU SHALL return all-ones; REM/REMU SHALL return op_a.
REQ-024 Signed overflow (op_a=0x8000_0000, op_b=0xFFFF_FFFF): DIV SHALL return 0x8000_0000 and REM SHALL return 0.
REQ-025 result SHALL update only at the edge entering DONE and SHALL hold that value until the next completion.
REQ-026 kill=1 at any edge SHALL force IDLE next cycle, with no done pulse and result unchanged.
REQ-027 kill SHALL take priority over start when both are high in IDLE, so the operation is not accepted.
REQ-028 kill in DONE SHALL not retract the done pulse in progress; the state still goes to IDLE.

Reset
REQ-029 rst=1 at an edge SHALL set state IDLE, the counter to 0, busy=0, done=0 and result=0; rst overrides kill and start.
REQ-030 rst asserted mid-CALC SHALL abandon the operation; no done pulse SHALL follow.

Verification
REQ-031 MUL: op_a=7, op_b=6 -> done exactly 33 cycles after acceptance, result=42; busy high for 33 cycles.
REQ-032 MULH: op_a=0xFFFF_FFFF (-1), op_b=0xFFFF_FFFF -> 0x0000_0000; MULHU on the same operands -> 0xFFFF_FFFE; MULHSU on the same operands -> 0xFFFF_FFFF.
REQ-033 DIV: -7/2 -> 0xFFFF_FFFD (-3); REM: -7 rem 2 -> 0xFFFF_FFFF (-1); DIVU: 100/7 -> 14; REMU: 100 rem 7 -> 2.
REQ-034 Special cases: DIVU 5/0 -> 0xFFFF_FFFF; REM 5/0 -> 5; DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM on the same operands -> 0, each at the normal 33-cycle latency.
REQ-035 Handshake: start pulsed again while busy, with new operands -> ignored, first result unchanged; kill at iteration 10 -> busy=0 next cycle, no done, result keeps its prior value; start+kill together in IDLE -> not accepted.
REQ-036 Reset: rst mid-CALC -> busy=0, done=0, result=0 next cycle; a new start after reset completes normally.
